// File: rtl/clint_multi_pkg.sv
// Shared constants, register-select types and address decode for the multi-hart CLINT.
package clint_multi_pkg;

  localparam int unsigned NHART_MAX          = 8;
  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;
  localparam int unsigned CLINT_ADDR_SPAN    = 32'h0001_0000;

  typedef enum logic [1:0] {RegNone, RegMsip, RegMtimecmp, RegMtime} clint_reg_e;

  typedef struct packed {
    clint_reg_e kind;
    logic [2:0] hart;
  } clint_sel_t;

  // Offset is relative to the CLINT base and already known to fall inside the span.
  function automatic clint_sel_t clint_decode(input logic [15:0] off, input int unsigned nhart);
    clint_sel_t sel;
    sel.kind = RegNone;
    sel.hart = '0;
    for (int unsigned h = 0; h < NHART_MAX; h++) begin
      if (h < nhart) begin
        if (off == CLINT_MSIP_OFF + 16'(4 * h)) begin
          sel.kind = RegMsip;
          sel.hart = 3'(h);
        end
        if (off == CLINT_MTIMECMP_OFF + 16'(8 * h)) begin
          sel.kind = RegMtimecmp;
          sel.hart = 3'(h);
        end
      end
    end
    if (off == CLINT_MTIME_OFF) begin
      sel.kind = RegMtime;
      sel.hart = '0;
    end
    return sel;
  endfunction

endpackage

// File: rtl/clint_hart_cmp.sv
// Per-hart mtimecmp register with byte strobes, the re-arm flag and the timer IRQ.
module clint_hart_cmp
  import clint_multi_pkg::*;
#(
  parameter int unsigned     XLEN          = 64,
  parameter logic [XLEN-1:0] MTIMECMP_INIT = '1
) (
  input  logic                cpu_clk_50M,
  input  logic                cpu_rst_n,
  input  logic                cmp_wr,
  input  logic [XLEN-1:0]     write_data,
  input  logic [XLEN/8-1:0]   write_strb,
  input  logic [XLEN-1:0]     mtime,
  input  logic                mtip_ack,
  output logic [XLEN-1:0]     mtimecmp,
  output logic                mtip
);

  logic [XLEN-1:0] cmp_q, cmp_d;
  logic            arm_q, arm_d;

  always_comb begin
    cmp_d = cmp_q;
    if (cmp_wr) begin
      for (int i = 0; i < XLEN / 8; i++) begin
        if (write_strb[i]) cmp_d[8*i +: 8] = write_data[8*i +: 8];
      end
    end
  end

  // Ack has priority over both re-arm causes.
  always_comb begin
    arm_d = arm_q;
    if (mtip_ack) begin
      arm_d = 1'b0;
    end else if (cmp_wr || (mtime < cmp_q)) begin
      arm_d = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      cmp_q <= MTIMECMP_INIT;
      arm_q <= 1'b1;
    end else begin
      cmp_q <= cmp_d;
      arm_q <= arm_d;
    end
  end

  assign mtimecmp = cmp_q;
  assign mtip     = arm_q & (mtime >= cmp_q);

endmodule

// File: rtl/clint_multi.sv
// Multi-hart core-local interruptor: shared prescaled mtime, per-hart mtimecmp/msip,
// single-cycle MMIO read/write handshake.
module clint_multi
  import clint_multi_pkg::*;
#(
  parameter int unsigned     NHART         = 2,
  parameter int unsigned     XLEN          = 64,
  parameter int unsigned     TICK_DIV      = 1,
  parameter logic [XLEN-1:0] BASE_ADDR     = XLEN'(32'h0200_0000),
  parameter logic [XLEN-1:0] MTIME_INIT    = '0,
  parameter logic [XLEN-1:0] MTIMECMP_INIT = '1
) (
  input  logic                cpu_clk_50M,
  input  logic                cpu_rst_n,
  input  logic                read_en,
  input  logic [XLEN-1:0]     read_addr,
  output logic [XLEN-1:0]     data_read,
  output logic                read_valid,
  input  logic                write_en,
  input  logic [XLEN-1:0]     write_addr,
  input  logic [XLEN-1:0]     data_write,
  input  logic [XLEN/8-1:0]   write_strb,
  output logic                write_done,
  output logic                addr_err,
  output logic [NHART-1:0]    mtip,
  output logic [NHART-1:0]    msip,
  input  logic [NHART-1:0]    mtip_ack
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [XLEN-1:0]  mtime_q, mtime_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [NHART-1:0] msip_q, msip_d;
  logic [XLEN-1:0]  data_read_q, rdata;
  logic             read_valid_q, write_done_q, addr_err_q;
  logic [XLEN-1:0]  cmp_val [NHART];
  logic [NHART-1:0] cmp_wr;
  logic             mtime_wr;
  clint_sel_t       rd_sel, wr_sel;

  function automatic clint_sel_t decode_addr(input logic [XLEN-1:0] addr);
    logic [XLEN-1:0] off;
    clint_sel_t      sel;
    off = addr - BASE_ADDR;
    if (off >= XLEN'(CLINT_ADDR_SPAN)) begin
      sel.kind = RegNone;
      sel.hart = '0;
    end else begin
      sel = clint_decode(off[15:0], NHART);
    end
    return sel;
  endfunction

  assign rd_sel   = decode_addr(read_addr);
  assign wr_sel   = decode_addr(write_addr);
  assign mtime_wr = write_en && (wr_sel.kind == RegMtime);

  always_comb begin
    rdata = '0;
    unique case (rd_sel.kind)
      RegMsip: begin
        for (int h = 0; h < NHART; h++) begin
          if (rd_sel.hart == 3'(h)) rdata = XLEN'(msip_q[h]);
        end
      end
      RegMtimecmp: begin
        for (int h = 0; h < NHART; h++) begin
          if (rd_sel.hart == 3'(h)) rdata = cmp_val[h];
        end
      end
      RegMtime: rdata = mtime_q;
      default:  rdata = '0;
    endcase
  end

  // A software write to mtime replaces this cycle's tick and restarts the prescaler.
  always_comb begin
    mtime_d = mtime_q;
    presc_d = presc_q + PW'(1);
    if (presc_q == PW'(TICK_DIV - 1)) begin
      presc_d = '0;
      mtime_d = mtime_q + XLEN'(1);
    end
    if (mtime_wr) begin
      presc_d = '0;
      mtime_d = mtime_q;
      for (int i = 0; i < XLEN / 8; i++) begin
        if (write_strb[i]) mtime_d[8*i +: 8] = data_write[8*i +: 8];
      end
    end
  end

  always_comb begin
    msip_d = msip_q;
    cmp_wr = '0;
    for (int h = 0; h < NHART; h++) begin
      if (write_en && (wr_sel.hart == 3'(h))) begin
        if ((wr_sel.kind == RegMsip) && write_strb[0]) msip_d[h] = data_write[0];
        cmp_wr[h] = (wr_sel.kind == RegMtimecmp);
      end
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      mtime_q      <= MTIME_INIT;
      presc_q      <= '0;
      msip_q       <= '0;
      data_read_q  <= '0;
      read_valid_q <= 1'b0;
      write_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      mtime_q      <= mtime_d;
      presc_q      <= presc_d;
      msip_q       <= msip_d;
      data_read_q  <= read_en ? rdata : '0;
      read_valid_q <= read_en;
      write_done_q <= write_en;
      addr_err_q   <= (read_en && (rd_sel.kind == RegNone)) ||
                      (write_en && (wr_sel.kind == RegNone));
    end
  end

  for (genvar h = 0; h < NHART; h++) begin : g_hart
    clint_hart_cmp #(
      .XLEN          (XLEN),
      .MTIMECMP_INIT (MTIMECMP_INIT)
    ) u_cmp (
      .cpu_clk_50M (cpu_clk_50M),
      .cpu_rst_n   (cpu_rst_n),
      .cmp_wr      (cmp_wr[h]),
      .write_data  (data_write),
      .write_strb  (write_strb),
      .mtime       (mtime_q),
      .mtip_ack    (mtip_ack[h]),
      .mtimecmp    (cmp_val[h]),
      .mtip        (mtip[h])
    );
  end

  assign data_read  = data_read_q;
  assign read_valid = read_valid_q;
  assign write_done = write_done_q;
  assign addr_err   = addr_err_q;
  assign msip       = msip_q;

endmodule

// File: tb/tb_clint_multi.sv
// Bench for clint_multi: two instances (TICK_DIV 1 and 4) on one bus, checked every cycle
// against a time-based reference model, plus directed checks with fixed expected values.
module tb_clint_multi;

  localparam logic [63:0] BASE   = 64'h0200_0000;
  localparam logic [63:0] A_MSIP = BASE;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_MT   = BASE + 64'hBFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_en, write_en;
  logic [63:0] read_addr, write_addr, data_write;
  logic [7:0]  write_strb;
  logic [1:0]  mtip_ack;
  logic [63:0] data_read [2];
  logic        read_valid [2];
  logic        write_done [2];
  logic        addr_err [2];
  logic [1:0]  mtip [2];
  logic [1:0]  msip [2];

  always #5 clk = ~clk;

  clint_multi #(.TICK_DIV(1)) u_d1 (
    .cpu_clk_50M (clk),           .cpu_rst_n  (rst_n),
    .read_en     (read_en),       .read_addr  (read_addr),
    .data_read   (data_read[0]),  .read_valid (read_valid[0]),
    .write_en    (write_en),      .write_addr (write_addr),
    .data_write  (data_write),    .write_strb (write_strb),
    .write_done  (write_done[0]), .addr_err   (addr_err[0]),
    .mtip        (mtip[0]),       .msip       (msip[0]),
    .mtip_ack    (mtip_ack)
  );

  clint_multi #(.TICK_DIV(4)) u_d4 (
    .cpu_clk_50M (clk),           .cpu_rst_n  (rst_n),
    .read_en     (read_en),       .read_addr  (read_addr),
    .data_read   (data_read[1]),  .read_valid (read_valid[1]),
    .write_en    (write_en),      .write_addr (write_addr),
    .data_write  (data_write),    .write_strb (write_strb),
    .write_done  (write_done[1]), .addr_err   (addr_err[1]),
    .mtip        (mtip[1]),       .msip       (msip[1]),
    .mtip_ack    (mtip_ack)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: mtime is a closed-form function of the cycle number since its last load.
  logic [63:0] mt_base [2];
  int          mt_cyc [2];
  logic [63:0] cmp_m [2][2];
  logic        sip_m [2][2];
  logic        arm_m [2][2];
  logic [63:0] e_rdata [2];
  logic        e_rvalid, e_wdone, e_aerr;

  function automatic int divk(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [63:0] mtime_at(input int k, input int t);
    return mt_base[k] + 64'((t - mt_cyc[k]) / divk(k));
  endfunction

  // -1 unmapped, 0..1 msip hart, 10..11 mtimecmp hart, 20 mtime
  function automatic int where(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    if (off == 64'hBFF8) return 20;
    if (off < 64'd8 && off % 4 == 0) return int'(off / 4);
    if (off >= 64'h4000 && off < 64'h4010 && off % 8 == 0) return 10 + int'((off - 64'h4000) / 8);
    return -1;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_update();
    int          rw, ww;
    logic [63:0] mt_old;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mt_base[k] = '0;
        mt_cyc[k]  = cyc + 1;
        e_rdata[k] = '0;
        for (int h = 0; h < 2; h++) begin
          cmp_m[k][h] = '1;
          sip_m[k][h] = 1'b0;
          arm_m[k][h] = 1'b1;
        end
      end
      e_rvalid = 1'b0;
      e_wdone  = 1'b0;
      e_aerr   = 1'b0;
    end else begin
      rw = where(read_addr);
      ww = where(write_addr);
      e_rvalid = read_en;
      e_wdone  = write_en;
      e_aerr   = (read_en && rw < 0) || (write_en && ww < 0);
      for (int k = 0; k < 2; k++) begin
        mt_old = mtime_at(k, cyc);
        e_rdata[k] = '0;
        if (read_en) begin
          if (rw == 20) e_rdata[k] = mt_old;
          else if (rw >= 10) e_rdata[k] = cmp_m[k][rw-10];
          else if (rw >= 0) e_rdata[k] = {63'b0, sip_m[k][rw]};
        end
        for (int h = 0; h < 2; h++) begin
          if (mtip_ack[h]) arm_m[k][h] = 1'b0;
          else if ((write_en && ww == 10 + h) || mt_old < cmp_m[k][h]) arm_m[k][h] = 1'b1;
        end
        if (write_en) begin
          if (ww == 20) begin
            mt_base[k] = merge(mt_old, data_write, write_strb);
            mt_cyc[k]  = cyc + 1;
          end else if (ww >= 10) begin
            cmp_m[k][ww-10] = merge(cmp_m[k][ww-10], data_write, write_strb);
          end else if (ww >= 0 && write_strb[0]) begin
            sip_m[k][ww] = data_write[0];
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [1:0] em, es;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("read_valid[%0d]", k), 64'(read_valid[k]), 64'(e_rvalid));
      chk($sformatf("write_done[%0d]", k), 64'(write_done[k]), 64'(e_wdone));
      chk($sformatf("addr_err[%0d]", k), 64'(addr_err[k]), 64'(e_aerr));
      if (e_rvalid) chk($sformatf("data_read[%0d]", k), data_read[k], e_rdata[k]);
      for (int h = 0; h < 2; h++) begin
        em[h] = arm_m[k][h] && (mtime_at(k, cyc) >= cmp_m[k][h]);
        es[h] = sip_m[k][h];
      end
      chk($sformatf("mtip[%0d]", k), 64'(mtip[k]), 64'(em));
      chk($sformatf("msip[%0d]", k), 64'(msip[k]), 64'(es));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    write_en   = 1'b1;
    write_addr = a;
    data_write = d;
    write_strb = s;
    step();
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [63:0] a);
    read_en   = 1'b1;
    read_addr = a;
    step();
    read_en = 1'b0;
  endtask

  localparam int NADDR = 11;
  logic [63:0] addr_tab [NADDR];

  initial begin
    logic [63:0] cur;
    addr_tab = '{A_MSIP, A_MSIP + 64'd4, A_MSIP + 64'd8, A_CMP, A_CMP + 64'd8, A_CMP + 64'h10,
                 A_CMP + 64'd4, A_MT, BASE + 64'h8000, BASE + 64'h1_0000, BASE - 64'd8};
    rst_n = 1'b0; read_en = 1'b0; write_en = 1'b0; mtip_ack = 2'b00;
    read_addr = '0; write_addr = '0; data_write = '0; write_strb = '0;
    idle(3);
    chk("reset_mtip", 64'(mtip[0]), 64'd0);
    chk("reset_msip", 64'(msip[0]), 64'd0);
    rst_n = 1'b1;

    // Consecutive mtime reads on the undivided instance.
    read_en = 1'b1; read_addr = A_MT;
    idle(3);
    read_en = 1'b0;

    // Prescaler: 8 clocks after the load, mtime has advanced by 2 at TICK_DIV=4.
    wr(A_MT, 64'h10, 8'hFF);
    idle(8);
    rd(A_MT);
    chk("t2_div4_mtime", data_read[1], 64'h12);
    chk("t2_div1_mtime", data_read[0], 64'h18);

    // mtip[1] fires exactly when mtime reaches mtimecmp[1].
    wr(A_MT, 64'h1C, 8'hFF);
    wr(A_CMP + 64'd8, 64'h20, 8'hFF);
    idle(2);
    chk("t3_before", 64'(mtip[0]), 64'd0);
    step();
    chk("t3_fire", 64'(mtip[0]), 64'h2);

    // Ack masks mtip until a mtimecmp write re-arms it.
    mtip_ack = 2'b10;
    step();
    mtip_ack = 2'b00;
    chk("t4_acked", 64'(mtip[0][1]), 64'd0);
    idle(2);
    chk("t4_masked", 64'(mtip[0][1]), 64'd0);
    cur = mtime_at(0, cyc);
    wr(A_CMP + 64'd8, cur - 64'd1, 8'hFF);
    chk("t4_rearm", 64'(mtip[0][1]), 64'd1);

    // Partial-strobe write keeps the unstrobed upper word.
    wr(A_CMP, 64'hDEAD_BEEF, 8'h0F);
    rd(A_CMP);
    chk("t5_strb", data_read[0], 64'hFFFF_FFFF_DEAD_BEEF);

    // msip keeps bit 0 only; unmapped write completes with an error and changes nothing.
    wr(A_MSIP + 64'd4, 64'hFFFF, 8'hFF);
    chk("t6_msip", 64'(msip[0]), 64'h2);
    rd(A_MSIP + 64'd4);
    chk("t6_msip_rd", data_read[0], 64'd1);
    wr(BASE + 64'h8000, 64'h1, 8'hFF);
    chk("t6_unm_done", 64'(write_done[0]), 64'd1);
    chk("t6_unm_err", 64'(addr_err[0]), 64'd1);
    chk("t6_unm_msip", 64'(msip[0]), 64'h2);
    rd(BASE + 64'h8000);
    chk("t6_unm_rd", data_read[0], 64'd0);

    // Same-cycle read and write: read sees the old value.
    read_en = 1'b1; read_addr = A_CMP;
    wr(A_CMP, 64'h55, 8'hFF);
    read_en = 1'b0;
    chk("rw_old", data_read[0], 64'hFFFF_FFFF_DEAD_BEEF);
    rd(A_CMP);
    chk("rw_new", data_read[0], 64'h55);

    // mtime wraps at 2^64.
    wr(A_MT, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    idle(3);
    rd(A_MT);
    chk("wrap", data_read[0], 64'd1);

    // Reset during a transaction suppresses completions.
    read_en = 1'b1; write_en = 1'b1; read_addr = A_MT; write_addr = A_MT; rst_n = 1'b0;
    step();
    chk("rst_mid_rv", 64'(read_valid[0]), 64'd0);
    chk("rst_mid_wd", 64'(write_done[0]), 64'd0);
    read_en = 1'b0; write_en = 1'b0; rst_n = 1'b1;
    step();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      read_en    = ($urandom_range(0, 1) == 1);
      read_addr  = addr_tab[$urandom_range(0, NADDR - 1)];
      write_en   = ($urandom_range(0, 2) == 0);
      write_addr = addr_tab[$urandom_range(0, NADDR - 1)];
      write_strb = 8'($urandom);
      if ($urandom_range(0, 1) == 1) data_write = {$urandom, $urandom};
      else data_write = 64'($urandom_range(0, 1024));
      mtip_ack   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      step();
    end
    read_en = 1'b0; write_en = 1'b0; mtip_ack = 2'b00;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
